// File: rtl/config_readback.sv
// Config readback: snapshots the PE unit config and crossbar selects on request
// and streams them out as INST_WIDTH words over a valid/ready interface.
module config_readback #(
  parameter int unsigned INST_WIDTH      = 64,
  parameter int unsigned CONFIG_CMAC     = 16,
  parameter int unsigned CONFIG_LOGI     = 9,
  parameter int unsigned CONFIG_CORDIC   = 8,
  parameter int unsigned CONFIG_DMEM     = 31,
  parameter int unsigned CONFIG_ALL      = CONFIG_CMAC + CONFIG_LOGI + CONFIG_CORDIC + CONFIG_DMEM,
  parameter int unsigned NUM_INPUTS_CB1  = 14,
  parameter int unsigned NUM_OUTPUTS_CB1 = 16,
  parameter int unsigned NUM_INPUTS_CB2  = 10,
  parameter int unsigned NUM_OUTPUTS_CB2 = 4,
  parameter int unsigned SKIP_ZERO_CB    = 0
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   snap_req,
  input  logic [CONFIG_ALL-1:0]                                  config_all_i,
  input  logic [NUM_OUTPUTS_CB1*$clog2(NUM_INPUTS_CB1)-1:0]      config_cb1_i,
  input  logic [NUM_OUTPUTS_CB2*$clog2(NUM_INPUTS_CB2)-1:0]      config_cb2_i,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [INST_WIDTH-1:0]                                  out_data,
  output logic [1:0]                                             out_kind,
  output logic                                                   out_last,
  output logic                                                   busy,
  output logic                                                   overrun
);

  localparam int unsigned CW1 = $clog2(NUM_INPUTS_CB1);
  localparam int unsigned CW2 = $clog2(NUM_INPUTS_CB2);
  localparam int unsigned IW  = 4;
  localparam int unsigned V1W = NUM_OUTPUTS_CB1 * CW1;
  localparam int unsigned V2W = NUM_OUTPUTS_CB2 * CW2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UNIT = 2'd1,
    CB1  = 2'd2,
    CB2  = 2'd3
  } state_t;

  state_t                state, nxt_state;
  logic [IW-1:0]         idx, nxt_idx;
  logic [CONFIG_ALL-1:0] snap_all, src_all;
  logic [V1W-1:0]        snap_cb1, src_cb1;
  logic [V2W-1:0]        snap_cb2, src_cb2;
  logic                  capture, hs, nxt_last;
  logic [IW+1:0]         nxt_ptr;
  logic [INST_WIDTH+1:0] nxt_word;

  // Lowest CB1 index >= start that is emitted; returns {found, index}.
  function automatic logic [IW:0] scan_cb1(input logic [V1W-1:0] v, input logic [IW:0] start);
    logic [IW:0] r;
    r = '0;
    for (int k = int'(NUM_OUTPUTS_CB1) - 1; k >= 0; k--) begin
      if (((IW+1)'(k) >= start) && (SKIP_ZERO_CB == 0 || v[k*CW1 +: CW1] != '0)) begin
        r = {1'b1, IW'(k)};
      end
    end
    return r;
  endfunction

  // Lowest CB2 index >= start that is emitted; returns {found, index}.
  function automatic logic [IW:0] scan_cb2(input logic [V2W-1:0] v, input logic [IW:0] start);
    logic [IW:0] r;
    r = '0;
    for (int k = int'(NUM_OUTPUTS_CB2) - 1; k >= 0; k--) begin
      if (((IW+1)'(k) >= start) && (SKIP_ZERO_CB == 0 || v[k*CW2 +: CW2] != '0)) begin
        r = {1'b1, IW'(k)};
      end
    end
    return r;
  endfunction

  // Stream position following (st, ix); {IDLE, 0} when the stream ends there.
  function automatic logic [IW+1:0] advance(input state_t st, input logic [IW-1:0] ix,
                                            input logic [V1W-1:0] c1, input logic [V2W-1:0] c2);
    logic [IW:0]   s1, s2;
    logic [IW+1:0] r;
    r  = {IDLE, IW'(0)};
    s1 = '0;
    s2 = '0;
    case (st)
      UNIT: begin
        s1 = scan_cb1(c1, '0);
        s2 = scan_cb2(c2, '0);
      end
      CB1: begin
        s1 = scan_cb1(c1, {1'b0, ix} + 1'b1);
        s2 = scan_cb2(c2, '0);
      end
      CB2:     s2 = scan_cb2(c2, {1'b0, ix} + 1'b1);
      default: ;
    endcase
    if (s1[IW]) begin
      r = {CB1, s1[IW-1:0]};
    end else if (s2[IW]) begin
      r = {CB2, s2[IW-1:0]};
    end
    return r;
  endfunction

  // Word presented at position (st, ix); returns {kind, data}.
  function automatic logic [INST_WIDTH+1:0] word_of(input state_t st, input logic [IW-1:0] ix,
                                                    input logic [CONFIG_ALL-1:0] a,
                                                    input logic [V1W-1:0] c1, input logic [V2W-1:0] c2);
    logic [INST_WIDTH-1:0] d;
    logic [1:0]            k;
    d = '0;
    k = 2'd0;
    case (st)
      UNIT: d[CONFIG_ALL-1:0] = a;
      CB1: begin
        k          = 2'd1;
        d[IW-1:0]  = ix;
        d[8 +: CW1] = c1[int'(ix)*CW1 +: CW1];
      end
      CB2: begin
        k          = 2'd2;
        d[IW-1:0]  = ix;
        d[8 +: CW2] = c2[int'(ix)*CW2 +: CW2];
      end
      default: ;
    endcase
    return {k, d};
  endfunction

  // Next stream position and the word/last flag it will present.
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    src_all   = snap_all;
    src_cb1   = snap_cb1;
    src_cb2   = snap_cb2;
    capture   = 1'b0;
    nxt_ptr   = '0;
    hs        = out_valid & out_ready;
    if (state == IDLE) begin
      // Capture edge: the word is built straight from the live inputs.
      src_all = config_all_i;
      src_cb1 = config_cb1_i;
      src_cb2 = config_cb2_i;
      if (snap_req) begin
        capture   = 1'b1;
        nxt_state = UNIT;
        nxt_idx   = '0;
      end
    end else if (hs) begin
      nxt_ptr   = advance(state, idx, snap_cb1, snap_cb2);
      nxt_state = state_t'(nxt_ptr[IW+1:IW]);
      nxt_idx   = nxt_ptr[IW-1:0];
    end
    nxt_word = word_of(nxt_state, nxt_idx, src_all, src_cb1, src_cb2);
    nxt_last = (nxt_state != IDLE) &&
               (advance(nxt_state, nxt_idx, src_cb1, src_cb2) == {IDLE, IW'(0)});
  end

  // Stream position register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= nxt_state;
      idx   <= nxt_idx;
    end
  end

  // Snapshot capture and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_all  <= '0;
      snap_cb1  <= '0;
      snap_cb2  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      out_kind  <= 2'd0;
      out_last  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (capture) begin
        snap_all <= config_all_i;
        snap_cb1 <= config_cb1_i;
        snap_cb2 <= config_cb2_i;
      end
      out_valid <= (nxt_state != IDLE);
      busy      <= (nxt_state != IDLE);
      out_data  <= nxt_word[INST_WIDTH-1:0];
      out_kind  <= nxt_word[INST_WIDTH+1:INST_WIDTH];
      out_last  <= nxt_last;
      if (snap_req && state != IDLE) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_config_readback.sv
// Bench for config_readback: a word-list model built at capture time, checked
// every cycle against two instances (crossbar zero-skip off and on).
module tb_config_readback;

  localparam int unsigned CA = 64;
  localparam int unsigned N1 = 16;
  localparam int unsigned N2 = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned MAXW = 1 + N1 + N2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [1:0]        snap = 2'b00;
  logic              ready = 1'b1;
  logic [CA-1:0]     cfg_all = '0;
  logic [N1*CW-1:0]  cfg_cb1 = '0;
  logic [N2*CW-1:0]  cfg_cb2 = '0;

  logic [1:0]        o_valid, o_last, o_busy, o_ovr;
  logic [63:0]       o_data [2];
  logic [1:0]        o_kind [2];

  int n_chk = 0;
  int n_fail = 0;

  // model: expected word list per instance, filled at capture
  logic [63:0] ed [2][MAXW];
  logic [1:0]  ek [2][MAXW];
  logic        el [2][MAXW];
  int          elen [2] = '{0, 0};
  int          epos [2] = '{0, 0};
  logic        eov  [2] = '{1'b0, 1'b0};
  logic        pend [2] = '{1'b0, 1'b0};
  int          hs   [2] = '{0, 0};
  logic [63:0] seen_d [2][MAXW];
  logic [1:0]  seen_k [2][MAXW];
  logic        seen_l [2][MAXW];

  always #5 clk = ~clk;

  config_readback #(.SKIP_ZERO_CB(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .snap_req(snap[0]),
    .config_all_i(cfg_all), .config_cb1_i(cfg_cb1), .config_cb2_i(cfg_cb2),
    .out_valid(o_valid[0]), .out_ready(ready), .out_data(o_data[0]),
    .out_kind(o_kind[0]), .out_last(o_last[0]), .busy(o_busy[0]), .overrun(o_ovr[0])
  );

  config_readback #(.SKIP_ZERO_CB(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .snap_req(snap[1]),
    .config_all_i(cfg_all), .config_cb1_i(cfg_cb1), .config_cb2_i(cfg_cb2),
    .out_valid(o_valid[1]), .out_ready(ready), .out_data(o_data[1]),
    .out_kind(o_kind[1]), .out_last(o_last[1]), .busy(o_busy[1]), .overrun(o_ovr[1])
  );

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h, expected %h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Expected stream: unit word, then every (or every nonzero) select in ascending order.
  task automatic build(input int d);
    int n;
    logic [3:0] sel;
    n = 0;
    ed[d][0] = cfg_all; ek[d][0] = 2'd0; el[d][0] = 1'b0;
    n = 1;
    for (int i = 0; i < int'(N1); i++) begin
      sel = cfg_cb1[i*CW +: CW];
      if (d == 0 || sel != 4'd0) begin
        ed[d][n] = 64'(sel) * 256 + 64'(i); ek[d][n] = 2'd1; el[d][n] = 1'b0; n++;
      end
    end
    for (int j = 0; j < int'(N2); j++) begin
      sel = cfg_cb2[j*CW +: CW];
      if (d == 0 || sel != 4'd0) begin
        ed[d][n] = 64'(sel) * 256 + 64'(j); ek[d][n] = 2'd2; el[d][n] = 1'b0; n++;
      end
    end
    el[d][n-1] = 1'b1;
    elen[d] = n;
    epos[d] = 0;
  endtask

  // Model update on the active edge: consume accepted words, capture or flag overrun.
  always @(posedge clk or negedge rst_n) begin
    bit bz;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        epos[d] = 0; elen[d] = 0; eov[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        bz = epos[d] < elen[d];
        if (o_valid[d] && ready) hs[d]++;
        if (pend[d]) epos[d]++;
        if (snap[d]) begin
          if (bz) eov[d] = 1'b1;
          else build(d);
        end
      end
    end
  end

  // Compare process: every cycle on the falling edge.
  always @(negedge clk) begin
    bit bz;
    for (int d = 0; d < 2; d++) begin
      bz = epos[d] < elen[d];
      chk("out_valid", d, 64'(o_valid[d]), 64'(bz));
      chk("busy", d, 64'(o_busy[d]), 64'(bz));
      chk("overrun", d, 64'(o_ovr[d]), 64'(eov[d]));
      if (bz) begin
        chk("out_data", d, o_data[d], ed[d][epos[d]]);
        chk("out_kind", d, 64'(o_kind[d]), 64'(ek[d][epos[d]]));
        chk("out_last", d, 64'(o_last[d]), 64'(el[d][epos[d]]));
        seen_d[d][epos[d]] = o_data[d];
        seen_k[d][epos[d]] = o_kind[d];
        seen_l[d][epos[d]] = o_last[d];
      end
      pend[d] = bz && ready;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int d);
    snap[d] = 1'b1;
    step();
    snap[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int budget, input bit stall, output int cyc);
    cyc = 0;
    do begin
      if (stall) ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      step();
      cyc++;
    end while (o_busy[d] && cyc < budget);
    ready = 1'b1;
    chk("idle_within_budget", d, 64'(o_busy[d]), 64'd0);
  endtask

  task automatic set_cfg_a();
    cfg_all = 64'hDEAD_BEEF_0123_4567;
    for (int i = 0; i < int'(N1); i++) cfg_cb1[i*CW +: CW] = 4'(i % 14);
    for (int j = 0; j < int'(N2); j++) cfg_cb2[j*CW +: CW] = 4'(j + 1);
  endtask

  initial begin
    int c, base;
    #2 rst_n = 1'b0;
    repeat (3) step();
    chk("reset_data", 0, o_data[0], 64'd0);
    chk("reset_kind", 0, 64'(o_kind[0]), 64'd0);
    chk("reset_last", 0, 64'(o_last[0]), 64'd0);
    rst_n = 1'b1;
    step();

    // full stream, consumer always ready
    set_cfg_a();
    base = hs[0];
    pulse(0);
    wait_idle(0, 100, 1'b0, c);
    chk("latency_to_idle", 0, 64'(1 + c), 64'd22);
    chk("handshakes", 0, 64'(hs[0] - base), 64'd21);
    chk("word0_data", 0, seen_d[0][0], 64'hDEAD_BEEF_0123_4567);
    chk("word5_kind", 0, 64'(seen_k[0][5]), 64'd1);
    chk("word5_data", 0, seen_d[0][5], 64'h0000_0000_0000_0404);
    chk("word20_data", 0, seen_d[0][20], 64'h0000_0000_0000_0403);
    chk("word20_last", 0, 64'(seen_l[0][20]), 64'd1);
    step();

    // stalls with ready pattern 1,0,0,1 and a different config
    cfg_all = 64'h0F1E_2D3C_4B5A_6978;
    for (int i = 0; i < int'(N1); i++) cfg_cb1[i*CW +: CW] = 4'((i * 3) % 14);
    for (int j = 0; j < int'(N2); j++) cfg_cb2[j*CW +: CW] = 4'(9 - j);
    base = hs[0];
    pulse(0);
    wait_idle(0, 200, 1'b1, c);
    chk("stall_handshakes", 0, 64'(hs[0] - base), 64'd21);
    chk("stall_word0", 0, seen_d[0][0], 64'h0F1E_2D3C_4B5A_6978);
    chk("stall_word2", 0, seen_d[0][2], 64'h0000_0000_0000_0301);
    chk("stall_word20", 0, seen_d[0][20], 64'h0000_0000_0000_0603);
    step();

    // snapshot isolation: inputs cleared one cycle after the request
    set_cfg_a();
    base = hs[0];
    pulse(0);
    cfg_all = '0; cfg_cb1 = '0; cfg_cb2 = '0;
    wait_idle(0, 100, 1'b0, c);
    chk("iso_handshakes", 0, 64'(hs[0] - base), 64'd21);
    chk("iso_word0", 0, seen_d[0][0], 64'hDEAD_BEEF_0123_4567);
    chk("iso_word5", 0, seen_d[0][5], 64'h0000_0000_0000_0404);
    chk("iso_word20", 0, seen_d[0][20], 64'h0000_0000_0000_0403);
    step();

    // zero-skip: one nonzero entry per crossbar
    cfg_all = 64'h1111_2222_3333_4444; cfg_cb1 = '0; cfg_cb2 = '0;
    cfg_cb1[3*CW +: CW] = 4'd7;
    cfg_cb2[2*CW +: CW] = 4'd9;
    base = hs[1];
    pulse(1);
    wait_idle(1, 100, 1'b0, c);
    chk("skip_latency", 1, 64'(1 + c), 64'd4);
    chk("skip_handshakes", 1, 64'(hs[1] - base), 64'd3);
    chk("skip_word0", 1, seen_d[1][0], 64'h1111_2222_3333_4444);
    chk("skip_word1_kind", 1, 64'(seen_k[1][1]), 64'd1);
    chk("skip_word1", 1, seen_d[1][1], 64'h0000_0000_0000_0703);
    chk("skip_word2_kind", 1, 64'(seen_k[1][2]), 64'd2);
    chk("skip_word2", 1, seen_d[1][2], 64'h0000_0000_0000_0902);
    chk("skip_word2_last", 1, 64'(seen_l[1][2]), 64'd1);
    step();

    // zero-skip: all selects zero gives a lone unit word
    cfg_all = 64'hA5A5_5A5A_0F0F_F0F0; cfg_cb1 = '0; cfg_cb2 = '0;
    base = hs[1];
    pulse(1);
    wait_idle(1, 100, 1'b0, c);
    chk("allzero_latency", 1, 64'(1 + c), 64'd2);
    chk("allzero_handshakes", 1, 64'(hs[1] - base), 64'd1);
    chk("allzero_word0", 1, seen_d[1][0], 64'hA5A5_5A5A_0F0F_F0F0);
    chk("allzero_last", 1, 64'(seen_l[1][0]), 64'd1);
    step();

    // request at word 10 is ignored and flagged, then reset mid-stream
    set_cfg_a();
    pulse(0);
    repeat (10) step();
    pulse(0);
    chk("overrun_set", 0, 64'(o_ovr[0]), 64'd1);
    chk("stream_still_busy", 0, 64'(o_busy[0]), 64'd1);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 0, 64'(o_valid[0]), 64'd0);
    chk("rst_busy", 0, 64'(o_busy[0]), 64'd0);
    chk("rst_overrun", 0, 64'(o_ovr[0]), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    base = hs[0];
    pulse(0);
    wait_idle(0, 100, 1'b0, c);
    chk("post_rst_latency", 0, 64'(1 + c), 64'd22);
    chk("post_rst_handshakes", 0, 64'(hs[0] - base), 64'd21);
    chk("post_rst_word20", 0, seen_d[0][20], 64'h0000_0000_0000_0403);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
